// File: rtl/tug_pkg.sv
// rtl/tug_pkg.sv - shared state encoding and default timing for the key conditioner
package tug_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } key_state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/tug_key_conditioner_if.sv
// rtl/tug_key_conditioner_if.sv - press pulse bus from the key conditioner to the light row
interface tug_key_conditioner_if;

    logic L;
    logic R;
    logic tie;
    logic l_held;
    logic r_held;

    modport master (output L, output R, output tie, output l_held, output r_held);
    modport slave  (input  L, input  R, input  tie, input  l_held, input  r_held);

endinterface

// File: rtl/tug_key_conditioner_key_debounce.sv
// rtl/tug_key_conditioner_key_debounce.sv - synchroniser and press/release debounce FSM for one key
module key_debounce
    import tug_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic accept,
    output logic held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_s;
    key_state_t             state;
    logic [CNT_W-1:0]       cnt;

    // Resynchronise the raw key; reset loads the released level so no phantom press appears.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
        end
    end

    assign key_s = ~sync_q[SYNC_STAGES-1];

    // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!key_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Accept marks the PRESS_WAIT->HELD edge; the top registers it into the pulse outputs.
    assign accept = (state == PRESS_WAIT) && key_s && (cnt == CNT_LAST);
    assign held   = (state == HELD) || (state == RELEASE_WAIT);

endmodule

// File: rtl/tug_key_conditioner.sv
// rtl/tug_key_conditioner.sv - turns two bouncing push keys into clean L/R/tie press pulses
module tug_key_conditioner
    import tug_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_l_n,
    input  logic                          key_r_n,
    input  logic                          en,
    tug_key_conditioner_if.master         press
);

    logic acc_l;
    logic acc_r;
    logic held_l;
    logic held_r;

    key_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_l (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_l_n),
        .accept (acc_l),
        .held   (held_l)
    );

    key_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_r (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_r_n),
        .accept (acc_r),
        .held   (held_r)
    );

    // Simultaneous accepts collapse into a single tie pulse; en gates pulses only, never tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press.L   <= 1'b0;
            press.R   <= 1'b0;
            press.tie <= 1'b0;
        end else begin
            press.L   <= acc_l & en & ~acc_r;
            press.R   <= acc_r & en & ~acc_l;
            press.tie <= acc_l & acc_r & en;
        end
    end

    assign press.l_held = held_l;
    assign press.r_held = held_r;

endmodule

// File: tb/tb_tug_key_conditioner.sv
// tb/tb_tug_key_conditioner.sv - self-checking bench for tug_key_conditioner
module tb_tug_key_conditioner;

    localparam int DC = 4;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic key_l_n = 1'b1;
    logic key_r_n = 1'b1;
    logic en      = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    tug_key_conditioner_if press_if ();

    tug_key_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_l_n (key_l_n),
        .key_r_n (key_r_n),
        .en      (en),
        .press   (press_if)
    );

    always #50 clk = ~clk;

    // Reference model: each key's sampled level is the raw input two edges old; the
    // debounced level flips once DC consecutive samples disagree with it, and a
    // rising flip is a press. Index 0 = left, 1 = right.
    logic [1:0] m_d1, m_d2, m_lvl, m_s, m_flip, m_acc;
    int         m_run [2];
    logic       m_L, m_R, m_tie;

    always_comb begin
        m_s = 2'b00;
        m_flip = 2'b00;
        m_acc = 2'b00;
        for (int k = 0; k < 2; k++) begin
            m_s[k]    = ~m_d2[k];
            m_flip[k] = (m_s[k] != m_lvl[k]) && (m_run[k] >= DC - 1);
            m_acc[k]  = m_flip[k] && m_s[k];
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_d1     <= 2'b11;
            m_d2     <= 2'b11;
            m_lvl    <= 2'b00;
            m_run[0] <= 0;
            m_run[1] <= 0;
            m_L      <= 1'b0;
            m_R      <= 1'b0;
            m_tie    <= 1'b0;
        end else begin
            m_d1 <= {key_r_n, key_l_n};
            m_d2 <= m_d1;
            for (int k = 0; k < 2; k++) begin
                if (m_s[k] == m_lvl[k]) begin
                    m_run[k] <= 0;
                end else if (m_flip[k]) begin
                    m_run[k] <= 0;
                    m_lvl[k] <= m_s[k];
                end else begin
                    m_run[k] <= m_run[k] + 1;
                end
            end
            m_L   <= m_acc[0] & en & ~m_acc[1];
            m_R   <= m_acc[1] & en & ~m_acc[0];
            m_tie <= m_acc[0] & m_acc[1] & en;
        end
    end

    wire [4:0] dut_v = {press_if.L, press_if.R, press_if.tie, press_if.l_held, press_if.r_held};
    wire [4:0] mdl_v = {m_L, m_R, m_tie, m_lvl[0], m_lvl[1]};

    task automatic settle();
        key_l_n = 1'b1;
        key_r_n = 1'b1;
        en      = 1'b1;
        for (int c = 0; c < 12; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        int lp = 0;
        int first = -1;
        @(negedge clk);
        n_checks++;
        if (dut_v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_initial outputs got %b want %b", dut_v, 5'b0);
        end
        reset = 1'b1;
        key_l_n = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL reset_prehold c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
        end
        @(posedge clk);
        #20;
        reset = 1'b0;
        #1;
        n_checks++;
        if (dut_v !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_async outputs got %b want %b", dut_v, 5'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL reset_release c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.L) begin
                lp++;
                if (first < 0) first = c;
            end
        end
        n_checks++;
        if (lp != 1 || first != 6) begin
            n_fail++;
            $display("FAIL reset_repress pulses got %0d at %0d want 1 at 6", lp, first);
        end
        settle();
    endtask

    task automatic test_clean_press();
        int lp = 0;
        int others = 0;
        int first = -1;
        int last_held = -1;
        for (int c = 1; c <= 20; c++) begin
            key_l_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL clean_press c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.L) begin
                lp++;
                if (first < 0) first = c;
            end
            others += int'(press_if.R) + int'(press_if.tie);
        end
        n_checks++;
        if (lp != 1 || first != 6 || others != 0) begin
            n_fail++;
            $display("FAIL clean_pulse L=%0d at %0d others=%0d want 1 at 6 others=0", lp, first, others);
        end
        for (int c = 1; c <= 10; c++) begin
            key_l_n = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL clean_release c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.l_held) last_held = c;
        end
        n_checks++;
        if (last_held != 5) begin
            n_fail++;
            $display("FAIL clean_held_drop last held cycle got %0d want 5", last_held);
        end
        settle();
    endtask

    task automatic test_bounce();
        int rp = 0;
        int first = -1;
        logic pat [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic rel [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 1; c <= 24; c++) begin
            key_r_n = (c <= 8) ? pat[c-1] : 1'b0;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL bounce_press c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.R) begin
                rp++;
                if (first < 0) first = c;
            end
        end
        for (int c = 1; c <= 16; c++) begin
            key_r_n = (c <= 4) ? rel[c-1] : 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL bounce_release c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.R) rp++;
        end
        n_checks++;
        if (rp != 1 || first != 14) begin
            n_fail++;
            $display("FAIL bounce_pulse R=%0d at %0d want 1 at 14", rp, first);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int lp = 0, rp = 0, tp = 0;
        int fl = -1, fr = -1, ft = -1;
        for (int c = 1; c <= 12; c++) begin
            key_l_n = 1'b0;
            key_r_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL simul_same c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            lp += int'(press_if.L);
            rp += int'(press_if.R);
            if (press_if.tie) begin
                tp++;
                if (ft < 0) ft = c;
            end
        end
        n_checks++;
        if (tp != 1 || ft != 6 || lp != 0 || rp != 0) begin
            n_fail++;
            $display("FAIL simul_tie tie=%0d at %0d L=%0d R=%0d want 1 at 6 L=0 R=0", tp, ft, lp, rp);
        end
        settle();
        lp = 0; rp = 0; tp = 0;
        for (int c = 1; c <= 12; c++) begin
            key_l_n = 1'b0;
            key_r_n = (c >= 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL simul_stagger c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.L) begin lp++; if (fl < 0) fl = c; end
            if (press_if.R) begin rp++; if (fr < 0) fr = c; end
            tp += int'(press_if.tie);
        end
        n_checks++;
        if (lp != 1 || rp != 1 || fl != 6 || fr != 7 || tp != 0) begin
            n_fail++;
            $display("FAIL simul_stagger_pulses L=%0d@%0d R=%0d@%0d tie=%0d want L@6 R@7 tie=0", lp, fl, rp, fr, tp);
        end
        settle();
    endtask

    task automatic test_mask();
        int lp = 0;
        int first = -1;
        for (int c = 1; c <= 16; c++) begin
            key_l_n = 1'b0;
            en = (c >= 9);
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL mask_hold c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            lp += int'(press_if.L);
        end
        n_checks++;
        if (lp != 0) begin
            n_fail++;
            $display("FAIL mask_suppressed L pulses got %0d want 0", lp);
        end
        settle();
        lp = 0;
        for (int c = 1; c <= 10; c++) begin
            key_l_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL mask_repress c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            if (press_if.L) begin lp++; if (first < 0) first = c; end
        end
        n_checks++;
        if (lp != 1 || first != 6) begin
            n_fail++;
            $display("FAIL mask_next_press L=%0d at %0d want 1 at 6", lp, first);
        end
        settle();
    endtask

    task automatic test_long_hold();
        int lp = 0;
        for (int c = 1; c <= 200; c++) begin
            key_l_n = 1'b0;
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL long_hold c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
            lp += int'(press_if.L);
        end
        n_checks++;
        if (lp != 1) begin
            n_fail++;
            $display("FAIL long_hold_count L pulses got %0d want 1", lp);
        end
        settle();
    endtask

    task automatic test_random();
        for (int c = 1; c <= 800; c++) begin
            if ($urandom_range(0, 9) < 2) key_l_n = ~key_l_n;
            if ($urandom_range(0, 9) < 2) key_r_n = ~key_r_n;
            en = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            n_checks++;
            if (dut_v !== mdl_v) begin
                n_fail++;
                $display("FAIL random c=%0d outputs got %b want %b", c, dut_v, mdl_v);
            end
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_mask();
        test_long_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
